// File: rtl/riscv_lsu_if.sv
// Datapath and data-memory signal bundle for riscv_lsu.
// The LSU connects through the slave modport; the datapath/memory side uses master.
interface riscv_lsu_if;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic        dm_wr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport slave (
        input  req, is_store, funct3, addr, wdata, dm_rdata,
        output ready, done, err, rdata, dm_addr, dm_be, dm_wr, dm_wdata
    );

    modport master (
        output req, is_store, funct3, addr, wdata, dm_rdata,
        input  ready, done, err, rdata, dm_addr, dm_be, dm_wr, dm_wdata
    );
endinterface

// File: rtl/riscv_lsu.sv
// Multi-cycle RV32I load/store unit driving a word-indexed memory with registered read.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses with err and no access.
module riscv_lsu #(
    parameter int DM_DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    riscv_lsu_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_dm_addr;
    logic [3:0]  r_dm_be;
    logic        r_dm_wr;
    logic [31:0] r_dm_wdata;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_word_idx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_unused;

    assign w_accept   = bus.req && (r_state == S_IDLE);
    assign w_illegal  = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11)
                     || (bus.is_store && bus.funct3[2]);
    assign w_word_idx = {{(32-DM_DEPTH_LOG2){1'b0}}, bus.addr[DM_DEPTH_LOG2+1:2]};
    assign w_unused   = ^bus.addr[31:DM_DEPTH_LOG2+2];

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0])
                       || ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Lane placement: halfwords use addr[1] only, words ignore the offset.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << bus.addr[1:0];
                w_wdata = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = bus.dm_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = bus.dm_rdata[15:8];
            2'd2:    w_byte = bus.dm_rdata[23:16];
            2'd3:    w_byte = bus.dm_rdata[31:24];
            default: ;
        endcase
        w_half = r_off[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = bus.dm_rdata;
        endcase
    end

    // Memory controls are registered at accept so they are valid throughout ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_err      <= 1'b0;
            r_rdata    <= 32'h0;
            r_dm_addr  <= 32'h0;
            r_dm_be    <= 4'h0;
            r_dm_wr    <= 1'b0;
            r_dm_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_store <= bus.is_store;
                        r_funct3   <= bus.funct3;
                        r_off      <= bus.addr[1:0];
                        if (w_illegal || w_misaligned) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_err     <= 1'b0;
                            r_dm_addr <= w_word_idx;
                            r_state   <= S_ACCESS;
                            if (bus.is_store) begin
                                r_dm_wr    <= 1'b1;
                                r_dm_be    <= w_be;
                                r_dm_wdata <= w_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    r_dm_wr <= 1'b0;
                    r_dm_be <= 4'h0;
                    r_state <= r_is_store ? S_RESP : S_LOAD;
                end
                S_LOAD: begin
                    r_rdata <= w_load;
                    r_state <= S_RESP;
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = (r_state == S_IDLE);
    assign bus.done     = (r_state == S_RESP);
    assign bus.err      = (r_state == S_RESP) && r_err;
    assign bus.rdata    = r_rdata;
    assign bus.dm_addr  = r_dm_addr;
    assign bus.dm_be    = r_dm_be;
    assign bus.dm_wr    = r_dm_wr;
    assign bus.dm_wdata = r_dm_wdata;
endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu against a byte-addressed reference memory.
module tb_riscv_lsu;
    logic clk;
    logic rst_n;
    riscv_lsu_if bus();

    riscv_lsu #(.DM_DEPTH_LOG2(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory with registered read, byte-gated writes.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        bus.dm_rdata <= mem[bus.dm_addr[9:0]];
        if (bus.dm_wr) begin
            for (int i = 0; i < 4; i++)
                if (bus.dm_be[i]) mem[bus.dm_addr[9:0]][8*i +: 8] <= bus.dm_wdata[8*i +: 8];
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt   = 0;
    int          bad_be   = 0;
    int          txn_no   = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] exp_rdata;

    always @(negedge clk) begin
        if (bus.dm_wr) begin
            wr_cnt++;
            cap_addr  = bus.dm_addr;
            cap_be    = bus.dm_be;
            cap_wdata = bus.dm_wdata;
        end
        if (bus.dm_be != 4'h0 && !bus.dm_wr) bad_be++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
        int          size, off, base, lat, exp_lat;
        bit          ill, mis, exp_err;
        logic [31:0] val, exp_be, exp_wd, idx;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ill  = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (st && f3[2]);
        mis  = (a % size) != 0;
`ifdef LSU_MISALIGN_CHECK_EN
        exp_err = ill || mis;
`else
        exp_err = ill;
`endif
        idx  = (a >> 2) & 32'd1023;
        off  = (size == 4) ? 0 : (size == 2) ? int'(a & 2) : int'(a & 3);
        base = int'(idx) * 4 + off;
        exp_be = ((32'd1 << size) - 1) << off;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
        val = 0;
        for (int i = 0; i < size; i++) val |= 32'(ref_mem[base + i]) << (8*i);
        if (!f3[2] && size < 4 && val[8*size-1]) val |= ~((32'd1 << (8*size)) - 1);
        exp_lat = exp_err ? 1 : st ? 2 : 3;

        @(negedge clk);
        check_eq("ready_idle", bus.ready, 1);
        wr_cnt = 0;
        bus.req = 1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        if (!hold) bus.req = 0;
        bus.is_store = $urandom; bus.funct3 = $urandom; bus.addr = $urandom; bus.wdata = $urandom;
        if (!exp_err) begin
            check_eq("dm_addr", bus.dm_addr, idx);
            check_eq("dm_wr_access", bus.dm_wr, st);
        end else begin
            check_eq("dm_wr_err", bus.dm_wr, 0);
        end
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (bus.done) begin lat = c; break; end
        end
        if (!exp_err && !st) exp_rdata = val;
        check_eq("latency", lat, exp_lat);
        check_eq("err", bus.err, exp_err);
        check_eq("rdata", bus.rdata, exp_rdata);
        check_eq("ready_busy", bus.ready, 0);
        if (hold) begin @(negedge clk); bus.req = 0; end
        @(posedge clk); #1;
        check_eq("done_pulse", bus.done, 0);
        check_eq("ready_back", bus.ready, 1);
        check_eq("wr_count", wr_cnt, (st && !exp_err) ? 1 : 0);
        if (st && !exp_err) begin
            check_eq("st_addr", cap_addr, idx);
            check_eq("st_be", cap_be, exp_be);
            check_eq("st_wdata", cap_wdata, exp_wd);
            for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
        end
        check_eq("be_without_wr", bad_be, 0);
        $display("txn %0d st=%0d f3=%b addr=%h wd=%h hold=%0d -> rdata=%h err=%0d lat=%0d",
                 txn_no, st, f3, a, wd, hold, bus.rdata, bus.err, lat);
        txn_no++;
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = (i == 5) ? 32'd50 : $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        exp_rdata = 0;
        bus.req = 0; bus.is_store = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", bus.ready, 1);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        check_eq("rst_dm_addr", bus.dm_addr, 0);
        check_eq("rst_dm_be", bus.dm_be, 0);
        check_eq("rst_dm_wr", bus.dm_wr, 0);
        check_eq("rst_dm_wdata", bus.dm_wdata, 0);
        @(negedge clk); rst_n = 1;

        txn(0, 3'b010, 32'h14, 0, 0);           check_eq("plan_lw5", bus.rdata, 32'h32);
        txn(1, 3'b010, 32'h80, 32'hDEADBEEF, 0);
        txn(0, 3'b000, 32'h83, 0, 0);           check_eq("plan_lb", bus.rdata, 32'hFFFFFFDE);
        txn(0, 3'b100, 32'h83, 0, 0);           check_eq("plan_lbu", bus.rdata, 32'h000000DE);
        txn(0, 3'b001, 32'h82, 0, 0);           check_eq("plan_lh", bus.rdata, 32'hFFFFDEAD);
        txn(0, 3'b101, 32'h80, 0, 0);           check_eq("plan_lhu", bus.rdata, 32'h0000BEEF);
        txn(1, 3'b000, 32'h81, 32'h000000A5, 0);
        txn(0, 3'b010, 32'h80, 0, 0);           check_eq("plan_lw_sb", bus.rdata, 32'hDEADA5EF);
        txn(0, 3'b010, 32'h86, 0, 0);
        txn(0, 3'b011, 32'h10, 0, 0);
        txn(0, 3'b010, 32'h14, 0, 1);
        txn(0, 3'b010, 32'h80, 0, 0);
        txn(1, 3'b001, 32'h20000102, 32'h1234CAFE, 0);
        txn(0, 3'b001, 32'h102, 0, 0);          check_eq("plan_wrap", bus.rdata, 32'hFFFFCAFE);

        // Reset asserted while a store is in its ACCESS cycle.
        @(negedge clk);
        bus.req = 1; bus.is_store = 1; bus.funct3 = 3'b010; bus.addr = 32'h100; bus.wdata = 32'h12345678;
        @(posedge clk); #1;
        bus.req = 0;
        check_eq("rst_mid_wr_before", bus.dm_wr, 1);
        #1 rst_n = 0;
        #1;
        check_eq("rst_mid_dm_wr", bus.dm_wr, 0);
        check_eq("rst_mid_dm_be", bus.dm_be, 0);
        check_eq("rst_mid_ready", bus.ready, 1);
        check_eq("rst_mid_done", bus.done, 0);
        check_eq("rst_mid_rdata", bus.rdata, 0);
        check_eq("rst_mid_dm_wdata", bus.dm_wdata, 0);
        @(posedge clk); #1;
        check_eq("rst_mid_mem", mem[64], {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]});
        @(negedge clk); rst_n = 1;
        exp_rdata = 0;

        for (int k = 0; k < 300; k++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 1) == 1) ? ($urandom % 256) : $urandom;
            txn($urandom_range(0, 1), 3'($urandom_range(0, 7)), ra, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Multi-cycle load/store unit between the datapath and the word-indexed data memory. It accepts one load or store request per transaction and decodes RV32I funct3 into byte enables, replicated write data and a word address. It drives the memory for exactly one cycle, then extracts and sign- or zero-extends load data from the memory's registered read word. It returns the result with a one-cycle done pulse.

## Interface
- DM_DEPTH_LOG2, 10, log2 of data-memory depth in 32-bit words; dm_addr carries byte-address bits [DM_DEPTH_LOG2+1:2], with upper bits zero.
- Clock is `clk`; reset is `rst_n`, asynchronous, active-low. One clock domain.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe, accepted only when ready=1
- is_store  in  1  1=store, 0=load (sampled with req)
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective byte address
- wdata  in  32  store data (rs2), low bytes significant
- ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; misaligned or illegal funct3
- rdata  out  32  extended load result, held until next load completes
- dm_addr  out  32  word index to data memory
- dm_be  out  4  byte write enables
- dm_wr  out  1  memory write strobe
- dm_wdata  out  32  lane-aligned write data
- dm_rdata  in  32  memory read word, registered by memory on the edge dm_addr is presented

## Operation
- States: IDLE, ACCESS, LOAD, RESP.
- IDLE: on req=1, latch is_store, funct3, addr and wdata.
  - A legal, aligned request goes to ACCESS.
  - A misaligned request or illegal funct3 goes straight to RESP with err=1 and no memory access.
  - The illegal funct3 codes are 011, 110 and 111, plus any store funct3 other than 000, 001 or 010.
- Alignment rules: H/HU/SH require addr[0]=0; W/SW require addr[1:0]=00.
- ACCESS: drive dm_addr from the latched address. For a store, dm_wr=1 and dm_be/dm_wdata are set as below. A store then goes to RESP; a load goes to LOAD.
- Store lane rules:
  - SB: be = 0001 shifted left by addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 if addr[1]=0, 1100 if addr[1]=1; wdata = half replicated ×2.
  - SW: be = 1111; wdata = wdata.
- LOAD: dm_rdata is valid. Select the byte by addr[1:0] or the half by addr[1]. Sign-extend for B/H, zero-extend for BU/HU. Register the result into rdata and go to RESP.
- RESP: done=1 for one cycle, err as determined, then return to IDLE.
- Outside ACCESS-for-store, dm_wr=0 and dm_be=0000. The memory gates individual byte writes on dm_be, so be must never be nonzero without dm_wr.
- req while ready=0 is ignored; no queuing.
- Address bits above DM_DEPTH_LOG2+1 are dropped, so accesses wrap modulo memory size.

## Timing
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, dm_addr=0, dm_be=0, dm_wr=0, dm_wdata=0.
- Accept edge E0 (req & ready).
- Store: ACCESS during E0→E1, the memory writes at E1, done is high during E1→E2. ready returns after E2.
- Load: ACCESS E0→E1, LOAD E1→E2, rdata updates at E2, done is high E2→E3.
- Error: done and err are high E0→E1, and rdata is unchanged.
- rst_n low mid-transaction returns the block to IDLE immediately. It drops dm_wr/dm_be asynchronously, so no partial write occurs after reset assertion.
- dm_* outputs are registered: no combinational path from req/addr to the memory.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned accesses raise err as above and perform no access.
- LSU_MISALIGN_CHECK_EN undefined:
  - Alignment is not checked. The H offset uses addr[1] only, and W ignores addr[1:0]; the access is performed at the truncated offset.
  - err is asserted only for illegal funct3.
  - Latency follows the normal store/load paths.

## Test plan
- Reset with memory word 5 = 50: LW addr 0x14 → dm_addr=5, done at E3, rdata=0x00000032, err=0.
- SW addr 0x80, wdata 0xDEADBEEF → dm_addr=0x20, be=1111, dm_wr high one cycle. Then:
  - LB 0x83 → 0xFFFFFFDE
  - LBU 0x83 → 0x000000DE
  - LH 0x82 → 0xFFFFDEAD
  - LHU 0x80 → 0x0000BEEF
- SB addr 0x81, wdata 0x000000A5 → be=0010, dm_wdata=0xA5A5A5A5; a following LW 0x80 → 0xDEADA5EF.
- With the macro defined, LW 0x86 → done and err at E0→E1, dm_wr/dm_be stay 0, rdata unchanged. Without the macro, the same request completes at E3 with the word at 0x84.
- Funct3=011 load → err=1, no access. req held high during a busy load is ignored, and a second transaction starts only after ready=1.
- rst_n low during a store's ACCESS cycle → memory word unchanged, outputs at reset values, ready=1.
